// File: rtl/cla_add_sequencer_pkg.sv
// Shared constants and FSM encoding for the chunked carry-lookahead add sequencer.
// The optional subtract path is enabled by defining CLA_SEQ_SUB_EN.
package cla_add_sequencer_pkg;

  localparam int ADDER_WIDTH      = 16;
  localparam int N_CHUNKS_DEFAULT = 4;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

  // Chunk index width; never narrower than one bit so N_CHUNKS=1 still has a counter.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_add_sequencer_cla_adder.sv
// WIDTH-bit carry-lookahead adder built on a parallel-prefix (Kogge-Stone) carry tree.
// Shared by cla_add_sequencer, which feeds it one operand chunk per cycle.
module cla_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] gen_n;
  logic [WIDTH-1:0] prop_n;
  logic [WIDTH:0]   carry;

  always_comb begin
    gen    = a & b;
    prop   = a ^ b;
    gen_n  = gen;
    prop_n = prop;
    carry  = '0;
    // After the prefix tree, gen[i]/prop[i] cover the whole span of bits 0..i.
    for (int d = 1; d < WIDTH; d = d * 2) begin
      gen_n  = gen;
      prop_n = prop;
      for (int i = d; i < WIDTH; i++) begin
        gen_n[i]  = gen[i] | (prop[i] & gen[i-d]);
        prop_n[i] = prop[i] & prop[i-d];
      end
      gen  = gen_n;
      prop = prop_n;
    end
    carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = gen[i] | (prop[i] & cin);
    end
    sum  = (a ^ b) ^ carry[WIDTH-1:0];
    cout = carry[WIDTH];
  end

endmodule

// File: rtl/cla_add_sequencer.sv
// Multi-cycle wide adder: one shared ADDER_WIDTH-bit CLA processes N_CHUNKS chunks, LSB first.
// Define CLA_SEQ_SUB_EN to add the req_sub port and the A-B path (invert B, carry-in forced to 1).
module cla_add_sequencer
  import cla_add_sequencer_pkg::*;
#(
  parameter int  N_CHUNKS = N_CHUNKS_DEFAULT,
  localparam int OP_WIDTH = N_CHUNKS * ADDER_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [OP_WIDTH-1:0] req_a,
  input  logic [OP_WIDTH-1:0] req_b,
  input  logic                req_cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic                req_sub,
`endif
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [OP_WIDTH-1:0] rsp_sum,
  output logic                rsp_cout
);

  localparam int               IDX_W    = idx_width(N_CHUNKS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CHUNKS - 1);

  seq_state_e             state;
  seq_state_e             state_nxt;
  logic [IDX_W-1:0]       idx;
  logic                   carry;
  logic [OP_WIDTH-1:0]    a_q;
  logic [OP_WIDTH-1:0]    b_q;
  logic                   cout_q;
  logic [ADDER_WIDTH-1:0] a_ch   [N_CHUNKS];
  logic [ADDER_WIDTH-1:0] b_ch   [N_CHUNKS];
  logic [ADDER_WIDTH-1:0] sum_ch [N_CHUNKS];
  logic [ADDER_WIDTH-1:0] add_in1;
  logic [ADDER_WIDTH-1:0] add_in2;
  logic [ADDER_WIDTH-1:0] add_sum;
  logic                   add_cout;
  logic                   accept;
  logic                   last_chunk;
  logic                   init_carry;
`ifdef CLA_SEQ_SUB_EN
  logic                   sub_q;
`endif

  for (genvar gi = 0; gi < N_CHUNKS; gi++) begin : g_chunk
    assign a_ch[gi]                                = a_q[gi*ADDER_WIDTH +: ADDER_WIDTH];
    assign b_ch[gi]                                = b_q[gi*ADDER_WIDTH +: ADDER_WIDTH];
    assign rsp_sum[gi*ADDER_WIDTH +: ADDER_WIDTH]  = sum_ch[gi];
  end

  assign add_in1 = a_ch[idx];
`ifdef CLA_SEQ_SUB_EN
  assign add_in2    = sub_q ? ~b_ch[idx] : b_ch[idx];
  assign init_carry = req_sub ? 1'b1 : req_cin;
`else
  assign add_in2    = b_ch[idx];
  assign init_carry = req_cin;
`endif

  cla_adder #(
    .WIDTH (ADDER_WIDTH)
  ) u_cla_adder (
    .a    (add_in1),
    .b    (add_in2),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign req_ready  = (state == SEQ_IDLE);
  assign rsp_valid  = (state == SEQ_DONE);
  assign rsp_cout   = cout_q;
  assign accept     = req_valid && req_ready;
  assign last_chunk = (idx == IDX_LAST);

  always_comb begin
    state_nxt = state;
    unique case (state)
      SEQ_IDLE: if (accept)     state_nxt = SEQ_RUN;
      SEQ_RUN:  if (last_chunk) state_nxt = SEQ_DONE;
      SEQ_DONE: if (rsp_ready)  state_nxt = SEQ_IDLE;
      default:                  state_nxt = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEQ_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture on accept, then one chunk per RUN cycle with the carry chained through a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      cout_q <= 1'b0;
      for (int i = 0; i < N_CHUNKS; i++) begin
        sum_ch[i] <= '0;
      end
`ifdef CLA_SEQ_SUB_EN
      sub_q  <= 1'b0;
`endif
    end else begin
      unique case (state)
        SEQ_IDLE: begin
          if (accept) begin
            a_q   <= req_a;
            b_q   <= req_b;
            idx   <= '0;
            carry <= init_carry;
`ifdef CLA_SEQ_SUB_EN
            sub_q <= req_sub;
`endif
          end
        end
        SEQ_RUN: begin
          sum_ch[idx] <= add_sum;
          carry       <= add_cout;
          if (last_chunk) begin
            cout_q <= add_cout;
            idx    <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_add_sequencer.sv
// Directed and randomized scoreboard bench for cla_add_sequencer (ADDER_WIDTH=16, N_CHUNKS=4).
// Subtract cases are exercised only when CLA_SEQ_SUB_EN is defined.
module tb_cla_add_sequencer;
  import cla_add_sequencer_pkg::*;

  localparam int NC     = 4;
  localparam int OPW    = NC * ADDER_WIDTH;
  localparam int N_RAND = 2000;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [OPW-1:0] req_a     = '0;
  logic [OPW-1:0] req_b     = '0;
  logic           req_cin   = 1'b0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [OPW-1:0] rsp_sum;
  logic           rsp_cout;
`ifdef CLA_SEQ_SUB_EN
  logic           req_sub   = 1'b0;
`endif

  int             n_cmp = 0;
  int             n_err = 0;
  logic [OPW:0]   sb[$];
  logic [OPW:0]   exp_hold;
  logic           rnd_sub;

  always #5 clk = ~clk;

  cla_add_sequencer #(
    .N_CHUNKS (NC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
`ifdef CLA_SEQ_SUB_EN
    .req_sub   (req_sub),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  function automatic logic [OPW:0] model(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                         input logic cin, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + (OPW+1)'(1);
    return {1'b0, a} + {1'b0, b} + {{OPW{1'b0}}, cin};
  endfunction

  task automatic check(input string tag, input logic [OPW:0] obs, input logic [OPW:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; a response handshake completing on that edge is scored first.
  task automatic tick();
    logic [OPW:0] e;
    if (rsp_valid && rsp_ready) begin
      n_cmp++;
      assert (sb.size() != 0)
      else begin
        n_err++;
        $error("FAIL sb_underflow: observed response %h with no expected entry", {rsp_cout, rsp_sum});
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rsp_result", {rsp_cout, rsp_sum}, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input logic cin,
                      input logic sub, input logic [OPW:0] exp);
    int w;
    req_a     = a;
    req_b     = b;
    req_cin   = cin;
`ifdef CLA_SEQ_SUB_EN
    req_sub   = sub;
`endif
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 50) begin
      tick();
      w++;
    end
    n_cmp++;
    assert (req_ready)
    else begin
      n_err++;
      $error("FAIL accept_timeout: observed req_ready %b expected 1", req_ready);
    end
    sb.push_back(exp);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      tick();
      w++;
    end
    n_cmp++;
    assert (sb.size() == 0)
    else begin
      n_err++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    int issued;
    int cyc;
    int w;
    logic took;

    // Reset state
    #2;
    check("rst_req_ready", (OPW+1)'(req_ready), (OPW+1)'(1));
    check("rst_rsp_valid", (OPW+1)'(rsp_valid), (OPW+1)'(0));
    check("rst_rsp_sum",   {1'b0, rsp_sum},     '0);
    check("rst_rsp_cout",  (OPW+1)'(rsp_cout),  (OPW+1)'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Full carry ripple with exact latency
    rsp_ready = 1'b1;
    req_a     = 64'hFFFF_FFFF_FFFF_FFFF;
    req_b     = 64'h1;
    req_cin   = 1'b0;
    req_valid = 1'b1;
    check("t1_ready_idle", (OPW+1)'(req_ready), (OPW+1)'(1));
    sb.push_back({1'b1, 64'h0});
    tick();
    req_valid = 1'b0;
    check("t1_ready_run", (OPW+1)'(req_ready), (OPW+1)'(0));
    tick();
    tick();
    tick();
    check("t1_valid_at_3", (OPW+1)'(rsp_valid), (OPW+1)'(0));
    tick();
    check("t1_valid_at_4", (OPW+1)'(rsp_valid), (OPW+1)'(1));
    tick();
    check("t1_valid_after_hs", (OPW+1)'(rsp_valid), (OPW+1)'(0));

    // Per-chunk sums with carry-in
    send(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, 1'b0, {1'b0, 64'h0011_0022_0033_0045});
    send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0, {1'b1, 64'h0});
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, {1'b1, 64'h0});
    drain();

    // Back-pressure in DONE with a second request pending
    rsp_ready = 1'b0;
    exp_hold  = model(64'hDEAD_BEEF_0123_4567, 64'h8000_FFFF_FEDC_BA98, 1'b1, 1'b0);
    send(64'hDEAD_BEEF_0123_4567, 64'h8000_FFFF_FEDC_BA98, 1'b1, 1'b0, exp_hold);
    w = 0;
    while (!rsp_valid && w < 20) begin
      tick();
      w++;
    end
    req_a     = 64'h0000_0000_0000_0064;
    req_b     = 64'h0000_0000_0000_00C8;
    req_cin   = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid",  (OPW+1)'(rsp_valid), (OPW+1)'(1));
      check("hold_ready",  (OPW+1)'(req_ready), (OPW+1)'(0));
      check("hold_result", {rsp_cout, rsp_sum}, exp_hold);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("hold_valid_after_hs", (OPW+1)'(rsp_valid), (OPW+1)'(0));
    check("hold_ready_after_hs", (OPW+1)'(req_ready), (OPW+1)'(1));
    send(64'h0000_0000_0000_0064, 64'h0000_0000_0000_00C8, 1'b0, 1'b0, {1'b0, 64'd300});
    drain();

    // Asynchronous reset two chunks into an operation
    send(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 1'b0, {1'b0, 64'h3333_3333_3333_3333});
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_valid", (OPW+1)'(rsp_valid), (OPW+1)'(0));
    check("abort_ready", (OPW+1)'(req_ready), (OPW+1)'(1));
    check("abort_sum",   {1'b0, rsp_sum},     '0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(64'd3, 64'd4, 1'b0, 1'b0, {1'b0, 64'd7});
    drain();

`ifdef CLA_SEQ_SUB_EN
    // Subtraction: borrow and no-borrow, carry-in ignored
    send(64'd5, 64'd7, 1'b0, 1'b1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    send(64'd7, 64'd5, 1'b1, 1'b1, {1'b1, 64'd2});
    drain();
`endif

    // Random operations with request and response stalls
    issued  = 0;
    cyc     = 0;
    rnd_sub = 1'b0;
    while ((issued < N_RAND || sb.size() != 0 || req_valid) && cyc < 60000) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!req_valid && issued < N_RAND && $urandom_range(0, 1) == 1) begin
        req_a   = {$urandom, $urandom};
        req_b   = ($urandom_range(0, 7) == 0) ? ~req_a : {$urandom, $urandom};
        req_cin = 1'($urandom_range(0, 1));
`ifdef CLA_SEQ_SUB_EN
        rnd_sub = 1'($urandom_range(0, 1));
        req_sub = rnd_sub;
`endif
        req_valid = 1'b1;
      end
      took = 1'b0;
      if (req_valid && req_ready) begin
        sb.push_back(model(req_a, req_b, req_cin, rnd_sub));
        issued++;
        took = 1'b1;
      end
      tick();
      if (took) req_valid = 1'b0;
      cyc++;
    end
    n_cmp++;
    assert (cyc < 60000)
    else begin
      n_err++;
      $error("FAIL random_timeout: observed %0d issued %0d pending expected all retired", issued, sb.size());
    end

    rsp_ready = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
